// File: rtl/uart_byte_tx.sv
// uart_byte_tx: buffers bytes from the PROM dump engine in a small FIFO and
// serialises them as 8N1 UART frames, gated by host flow control.
//
// Optional feature macro: UART_BYTE_TX_HEX_EN
//   defined   -> each byte is sent as two ASCII uppercase hex frames (high
//                nibble first), with CR LF after every 16th byte.
//   undefined -> raw binary frames.
//
// Ports:
//   clk12m    sole clock (12 MHz)
//   reset     synchronous, active-high reset
//   din       byte from dump engine
//   dvalid    din valid this cycle
//   dready    FIFO can accept a byte this cycle
//   rts       host ready; high = new frames may start
//   tx        UART line, idle high
//   busy      frame on the line, FIFO non-empty, or hex/CRLF frames pending
//   overflow  sticky; a byte was offered while the FIFO was full
//   level     current FIFO occupancy
module uart_byte_tx #(
  parameter int unsigned CLK_DIV = 104,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk12m,
  input  logic             reset,
  input  logic [7:0]       din,
  input  logic             dvalid,
  output logic             dready,
  input  logic             rts,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [FIFO_AW:0] level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q;
  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic       full, wr_en, pop, bit_end, frame_slot, frame_go, extra_pending;
  logic [7:0] frame_byte;

  assign full       = (level_q == LevelFull);
  assign dready     = !full;
  assign wr_en      = dvalid && !full;
  assign bit_end    = (cnt_q == CntMax);
  // A new frame may only be launched from idle or at the last stop-bit cycle.
  assign frame_slot = (state_q == StIdle) || ((state_q == StStop) && bit_end);

`ifdef UART_BYTE_TX_HEX_EN
  typedef enum logic [1:0] {HxNone, HxLow, HxCr, HxLf} hex_e;

  hex_e       hx_q, hx_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] nbytes_q, nbytes_d;  // wraps every 16 source bytes

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    hx_d       = hx_q;
    lo_d       = lo_q;
    nbytes_d   = nbytes_q;
    pop        = 1'b0;
    frame_go   = 1'b0;
    frame_byte = 8'h00;
    if (frame_slot && rts) begin
      unique case (hx_q)
        HxNone: begin
          if (level_q != '0) begin
            pop        = 1'b1;
            frame_go   = 1'b1;
            frame_byte = hex_char(mem[rd_ptr_q][7:4]);
            lo_d       = mem[rd_ptr_q][3:0];
            hx_d       = HxLow;
          end
        end
        HxLow: begin
          frame_go   = 1'b1;
          frame_byte = hex_char(lo_q);
          nbytes_d   = nbytes_q + 4'd1;
          hx_d       = (nbytes_q == 4'd15) ? HxCr : HxNone;
        end
        HxCr: begin
          frame_go   = 1'b1;
          frame_byte = 8'h0D;
          hx_d       = HxLf;
        end
        HxLf: begin
          frame_go   = 1'b1;
          frame_byte = 8'h0A;
          hx_d       = HxNone;
        end
      endcase
    end
  end

  assign extra_pending = (hx_q != HxNone);

  always_ff @(posedge clk12m) begin
    if (reset) begin
      hx_q     <= HxNone;
      lo_q     <= '0;
      nbytes_q <= '0;
    end else begin
      hx_q     <= hx_d;
      lo_q     <= lo_d;
      nbytes_q <= nbytes_d;
    end
  end
`else
  always_comb begin
    pop        = 1'b0;
    frame_go   = 1'b0;
    frame_byte = mem[rd_ptr_q];
    if (frame_slot && rts && (level_q != '0)) begin
      pop      = 1'b1;
      frame_go = 1'b1;
    end
  end

  assign extra_pending = 1'b0;
`endif

  // Occupancy: a write and a pop in the same cycle cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (frame_go) begin
          state_d = StStart;
          shift_d = frame_byte;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (frame_go) begin
            state_d = StStart;
            shift_d = frame_byte;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk12m) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      overflow_q <= overflow_q | (dvalid && full);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk12m) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || (level_q != '0) || extra_pending;
  assign overflow = overflow_q;
  assign level    = level_q;

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Downstream consumer of the PROM dump byte stream.
- Accepts bytes from the dump engine over a valid/ready handshake and buffers them in a small FIFO.
- Serialises the bytes as 8N1 UART frames to the FTDI host link, with host flow control on `rts`.
- Replaces the ad-hoc per-nibble-slot TX shifting with a proper baud-timed transmitter.

Parameters:
- CLK_DIV, 104: clk12m cycles per UART bit (12 MHz / 115200). Must be >= 2.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk12m  input  1  sole clock, 12 MHz.
- reset  input  1  synchronous, active-high reset.
- din  input  8  byte from dump engine.
- dvalid  input  1  din valid this cycle.
- dready  output  1  FIFO can accept a byte this cycle.
- rts  input  1  host ready; high = new frames may start.
- tx  output  1  UART line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  output  1  sticky; a byte was offered while the FIFO was full.
- level  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - tx=1, busy=0, overflow=0, level=0, dready=1.
  - FIFO pointers cleared; FSM in IDLE; baud counter 0.
- Reset mid-frame:
  - tx returns to 1 on the next edge.
  - Buffered bytes are discarded.
  - No partial frame resumes.
- Write path:
  - Write occurs when dvalid && dready; the byte is counted in level on the next cycle.
  - dready = !full, derived from registered level only.
  - When the FIFO is full, a write offered in the same cycle as a pop is still rejected.
  - dvalid && !dready drops the byte and sets overflow (cleared only by reset).
- Pop: happens only on a frame start. Simultaneous accepted write and pop leave level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level!=0 && rts, pop the head byte into the shift register and go to START; tx=0 from the next edge.
  - START: tx=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits LSB first, each CLK_DIV cycles, bit index 0..7, then STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end of the last stop cycle, if level!=0 && rts, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length: exactly 10*CLK_DIV cycles.
- Latency: a byte written at cycle N into an empty, idle block with rts=1 gives tx low from edge N+2.
- rts:
  - Sampled only at frame-start decisions.
  - Deassertion mid-frame never truncates the frame.
  - rts low with data pending holds tx=1 and busy=1.
- Baud counter: counts 0..CLK_DIV-1 and wraps. Width is $clog2(CLK_DIV).
- level arithmetic: FIFO_AW+1 bits. Pointers wrap modulo 2**FIFO_AW. Full when level==2**FIFO_AW.

Optional Feature:
- Macro: UART_BYTE_TX_HEX_EN.
- Defined: each popped byte is sent as two frames, ASCII uppercase hex of the high nibble then the low nibble.
  - Nibble mapping: '0'-'9' = 0x30-0x39; 'A'-'F' = 0x41-0x46.
  - After every 16th byte since reset, two further frames are sent: CR 0x0D, then LF 0x0A.
  - rts is checked before every frame, including nibble and CR/LF frames.
  - The FIFO pops once per source byte, at the first nibble frame.
  - The byte counter resets with reset.
- Undefined: raw binary frames only; no nibble/CRLF logic synthesised.

Test Plan:
1. CLK_DIV=4, idle, rts=1, write 0x55 at cycle 0 -> tx low cycles 2-5, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; busy falls after the stop bit.
2. rts=0, write 16 bytes 0x00..0x0F -> level=16, dready=0. 17th write 0xFF -> overflow=1, byte dropped. Raise rts -> 16 frames 0x00..0x0F back-to-back, 40 cycles each, no gap; overflow stays 1.
3. rts high, 2 bytes queued, drop rts mid-frame 1 -> frame 1 completes fully, tx stays 1, level=1. Raise rts -> frame 2 starts at the next cycle.
4. Assert reset during DATA of a frame with 3 bytes queued -> tx=1, level=0, busy=0, overflow=0 next cycle. No residual frames.
5. Accepted write and frame-start pop in the same cycle at level=5 -> level stays 5; FIFO order preserved.
6. UART_BYTE_TX_HEX_EN, write 0xA7 -> frames 0x41, 0x37. Write 16 bytes 0x00 -> 32 frames of 0x30, then 0x0D, 0x0A.
